// File: rtl/onn_pattern_driver.sv
// Front-end sequencer for the 3x5 ONN: serializes one 15-pixel pattern, pulses load,
// waits a fixed settling interval, then returns the recognized number over valid/ready.
module onn_pattern_driver #(
    parameter int unsigned N_PIX      = 15,
    parameter int unsigned SETTLE_CYC = 256
) (
    input  logic             sclk,
    input  logic             re,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [N_PIX-1:0] pat_data,
    output logic             onn_data,
    output logic             onn_load,
    input  logic [1:0]       onn_num,
    output logic             res_valid,
    output logic [1:0]       res_num,
    input  logic             res_ready,
    output logic             busy
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam logic [3:0]    PixLast    = 4'(N_PIX - 1);
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StLoad,
        StSettle,
        StReport
    } state_e;

    state_e           state_q;
    logic [N_PIX-1:0] shreg_q;
    logic [3:0]       pix_cnt_q;
    logic [SW-1:0]    settle_cnt_q;
    logic             onn_data_q;
    logic             onn_load_q;
    logic             res_valid_q;
    logic [1:0]       res_num_q;

    // The only input-to-output path: reset gates the accept.
    assign pat_ready = (state_q == StIdle) && !re;
    assign busy      = (state_q != StIdle);
    assign onn_data  = onn_data_q;
    assign onn_load  = onn_load_q;
    assign res_valid = res_valid_q;
    assign res_num   = res_num_q;

    always_ff @(posedge sclk) begin
        if (re) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            pix_cnt_q    <= '0;
            settle_cnt_q <= '0;
            onn_data_q   <= 1'b0;
            onn_load_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_num_q    <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pat_valid) begin
                        // Pixel 0 goes straight to the output register; the rest queue up.
                        shreg_q    <= pat_data >> 1;
                        onn_data_q <= pat_data[0];
                        pix_cnt_q  <= '0;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    shreg_q   <= shreg_q >> 1;
                    pix_cnt_q <= pix_cnt_q + 4'd1;
                    if (pix_cnt_q == PixLast) begin
                        onn_data_q <= 1'b0;
                        onn_load_q <= 1'b1;
                        state_q    <= StLoad;
                    end else begin
                        onn_data_q <= shreg_q[0];
                    end
                end
                StLoad: begin
                    onn_load_q   <= 1'b0;
                    settle_cnt_q <= '0;
                    state_q      <= StSettle;
                end
                StSettle: begin
                    if (settle_cnt_q == SettleLast) begin
                        res_num_q   <= onn_num;
                        res_valid_q <= 1'b1;
                        state_q     <= StReport;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                StReport: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_onn_pattern_driver.sv
// Directed self-checking bench for onn_pattern_driver with a short settling interval.
module tb_onn_pattern_driver;

    localparam int unsigned S = 4;

    logic        sclk = 1'b0;
    logic        re = 1'b1;
    logic        pat_valid = 1'b0;
    logic        pat_ready;
    logic [14:0] pat_data = '0;
    logic        onn_data;
    logic        onn_load;
    logic [1:0]  onn_num = 2'b00;
    logic        res_valid;
    logic [1:0]  res_num;
    logic        res_ready = 1'b0;
    logic        busy;

    int total = 0;
    int bad = 0;

    onn_pattern_driver #(
        .N_PIX      (15),
        .SETTLE_CYC (S)
    ) dut (
        .sclk      (sclk),
        .re        (re),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_data  (pat_data),
        .onn_data  (onn_data),
        .onn_load  (onn_load),
        .onn_num   (onn_num),
        .res_valid (res_valid),
        .res_num   (res_num),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle; outputs then show that cycle's values.
    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    // Entered in cycle T+1, leaves in cycle T+17.
    task automatic ser_check(input logic [14:0] p, input bit noisy);
        for (int k = 0; k < 15; k++) begin
            if (noisy) begin
                pat_valid = 1'($urandom);
                pat_data  = 15'($urandom);
            end
            check($sformatf("ser_px%0d", k), 32'(onn_data), 32'(p[k]));
            check("ser_load0", 32'(onn_load), 0);
            check("ser_busy", 32'(busy), 1);
            check("ser_ready0", 32'(pat_ready), 0);
            step();
        end
        check("load_pulse", 32'(onn_load), 1);
        check("load_data0", 32'(onn_data), 0);
        step();
    endtask

    // Entered in cycle T+17, leaves in cycle T+17+S with the result expected.
    task automatic settle_check(input logic [1:0] num, input bit noisy);
        onn_num = ~num;
        for (int i = 0; i < int'(S); i++) begin
            if (i == 1) onn_num = num;
            if (noisy) begin
                pat_valid = 1'($urandom);
                pat_data  = 15'($urandom);
            end
            check("settle_valid0", 32'(res_valid), 0);
            check("settle_load0", 32'(onn_load), 0);
            check("settle_ready0", 32'(pat_ready), 0);
            step();
        end
        onn_num = ~num;
        check("res_valid1", 32'(res_valid), 1);
        check("res_num", 32'(res_num), 32'(num));
    endtask

    task automatic send(input logic [14:0] p, input logic [1:0] num, input bit noisy);
        pat_valid = 1'b1;
        pat_data  = p;
        check("accept_ready", 32'(pat_ready), 1);
        step();
        pat_valid = 1'b0;
        pat_data  = ~p;
        ser_check(p, noisy);
        settle_check(num, noisy);
        pat_valid = 1'b0;
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("hs_valid0", 32'(res_valid), 0);
        check("hs_ready1", 32'(pat_ready), 1);
        check("hs_busy0", 32'(busy), 0);
    endtask

    // Watch a quiet window for stray load pulses or results.
    task automatic quiet_check(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (onn_load || res_valid || busy) seen = 1'b1;
            step();
        end
        check(tag, 32'(seen), 0);
    endtask

    initial begin
        int n;

        // Reset state
        step();
        step();
        check("rst_ready_gated", 32'(pat_ready), 0);
        re = 1'b0;
        #1;
        check("rst_ready", 32'(pat_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'(onn_data), 0);
        check("rst_load", 32'(onn_load), 0);
        check("rst_valid", 32'(res_valid), 0);
        check("rst_num", 32'(res_num), 0);

        // Serialization, capture and ignored inputs during SHIFT/SETTLE
        send(15'h5555, 2'b10, 1'b1);
        pat_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_valid", 32'(res_valid), 1);
            check("hold_num", 32'(res_num), 2);
            check("hold_ready0", 32'(pat_ready), 0);
        end
        take_result();

        // Second pattern with different data/result
        send(15'h1a2b, 2'b01, 1'b0);
        take_result();

        // Back-to-back with both handshakes held high
        pat_valid = 1'b1;
        res_ready = 1'b1;
        pat_data  = 15'h0f0f;
        check("b2b_first_ready", 32'(pat_ready), 1);
        step();
        pat_data = 15'h3c71;
        n = 1;
        while (!pat_ready && n < 80) begin
            step();
            n++;
        end
        check("b2b_period", 32'(n), 32'(S + 18));
        step();
        pat_valid = 1'b0;
        pat_data  = 15'h0000;
        ser_check(15'h3c71, 1'b0);
        settle_check(2'b11, 1'b0);
        step();
        res_ready = 1'b0;
        check("b2b_valid0", 32'(res_valid), 0);
        check("b2b_idle", 32'(pat_ready), 1);

        // Reset mid-SHIFT (pattern all ones so data would be 1 without reset)
        pat_valid = 1'b1;
        pat_data  = 15'h7fff;
        step();
        pat_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        re = 1'b1;
        #1;
        check("rs_ready_gated", 32'(pat_ready), 0);
        step();
        check("rs_data0", 32'(onn_data), 0);
        check("rs_load0", 32'(onn_load), 0);
        check("rs_valid0", 32'(res_valid), 0);
        check("rs_busy0", 32'(busy), 0);
        re = 1'b0;
        #1;
        check("rs_ready1", 32'(pat_ready), 1);
        quiet_check("rs_quiet");

        // Reset mid-SETTLE
        pat_valid = 1'b1;
        pat_data  = 15'h2aaa;
        step();
        pat_valid = 1'b0;
        ser_check(15'h2aaa, 1'b0);
        step();
        re = 1'b1;
        step();
        check("rt_data0", 32'(onn_data), 0);
        check("rt_load0", 32'(onn_load), 0);
        check("rt_valid0", 32'(res_valid), 0);
        check("rt_busy0", 32'(busy), 0);
        re = 1'b0;
        #1;
        check("rt_ready1", 32'(pat_ready), 1);
        quiet_check("rt_quiet");

        // Fresh pattern after resets
        send(15'h4d19, 2'b01, 1'b0);
        take_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
